// File: rtl/overlap_add.sv
`default_nettype none
// ============================================================================
// Module   : overlap_add
// Brief    : 50%-overlap add of synthesis-windowed frames, 1-cycle latency,
//            saturating (32,24) output, one hop of samples per frame.
// Revision : 1.0 - initial release
// ============================================================================
module overlap_add #(
  parameter int FRAME_LEN = 64,
  parameter int HOP       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        out_sat
);

  localparam int c_CNT_W = $clog2(FRAME_LEN);
  localparam int c_IDX_W = $clog2(HOP);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(FRAME_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_HOP_CNT  = c_CNT_W'(HOP);
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(HOP - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_tail [HOP];

  logic               w_first_half;
  logic [c_IDX_W-1:0] w_idx;
  logic [31:0]        w_tail;
  logic [32:0]        w_sum;
  logic [31:0]        w_sat_data;
  logic               w_sat;
  logic               w_emit;
  logic               w_wr;

  // Low index bits address the tail in both halves: cnt and cnt-HOP share them.
  assign w_first_half = (r_cnt < c_HOP_CNT);
  assign w_idx        = r_cnt[c_IDX_W-1:0];
  assign w_tail       = r_tail[w_idx];
  assign w_sum        = {in_data[31], in_data} + {w_tail[31], w_tail};
  assign w_emit       = in_valid & w_first_half;
  assign w_wr         = in_valid & ~w_first_half;

  always_comb begin
    w_sat_data = w_sum[31:0];
    w_sat      = 1'b0;
    case (w_sum[32:31])
      2'b01: begin
        w_sat_data = 32'h7FFF_FFFF;
        w_sat      = 1'b1;
      end
      2'b10: begin
        w_sat_data = 32'h8000_0000;
        w_sat      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (in_valid) begin
      r_cnt <= (r_cnt == c_CNT_MAX) ? '0 : r_cnt + 1'b1;
    end
  end

  // Reads happen only in the first half, writes only in the second, so a
  // tail entry is never read and written in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < HOP; i++) r_tail[i] <= '0;
    end else if (w_wr) begin
      r_tail[w_idx] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= w_emit;
      out_last  <= w_emit & (r_cnt == c_LAST_CNT);
      out_sat   <= w_emit & w_sat;
      if (w_emit) out_data <= w_sat_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_overlap_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_overlap_add
// Brief    : Directed, table-driven self-checking bench for overlap_add.
// Revision : 1.0 - initial release
// ============================================================================
module tb_overlap_add;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_sat;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] held = '0;

  overlap_add #(.FRAME_LEN(64), .HOP(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a: samples 0..31, b: samples 32..63, exp/exp_sat: every output of the frame
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          gap;
    logic [31:0] exp;
    logic        exp_sat;
  } frame_t;

  frame_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic expect_out(input string nm, input logic v, input logic [31:0] d,
                            input logic l, input logic s);
    chk({nm, ".valid"}, {31'b0, out_valid}, {31'b0, v});
    chk({nm, ".data"},  out_data, d);
    chk({nm, ".last"},  {31'b0, out_last},  {31'b0, l});
    chk({nm, ".sat"},   {31'b0, out_sat},   {31'b0, s});
  endtask

  task automatic send(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(0, 2);
    for (int g = 0; g < n; g++) begin
      send(1'b0, $urandom);
      expect_out("idle", 1'b0, held, 1'b0, 1'b0);
    end
  endtask

  task automatic run_frame(input frame_t f);
    for (int k = 0; k < 64; k++) begin
      if (f.gap) idle_gap();
      send(1'b1, (k < 32) ? f.a : f.b);
      if (k < 32) begin
        held = f.exp;
        expect_out("frame_out", 1'b1, f.exp, k == 31, f.exp_sat);
      end else begin
        expect_out("frame_tail", 1'b0, held, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    tbl[0] = '{a: 32'h0100_0000, b: 32'h0100_0000, gap: 1'b0, exp: 32'h0100_0000, exp_sat: 1'b0};
    tbl[1] = '{a: 32'h0100_0000, b: 32'h7F00_0000, gap: 1'b0, exp: 32'h0200_0000, exp_sat: 1'b0};
    tbl[2] = '{a: 32'h00FF_FFFF, b: 32'h8100_0000, gap: 1'b0, exp: 32'h7FFF_FFFF, exp_sat: 1'b0};
    tbl[3] = '{a: 32'hFE00_0000, b: 32'h7F00_0000, gap: 1'b0, exp: 32'h8000_0000, exp_sat: 1'b1};
    tbl[4] = '{a: 32'h0200_0000, b: 32'h0100_0000, gap: 1'b0, exp: 32'h7FFF_FFFF, exp_sat: 1'b1};
    tbl[5] = '{a: 32'h0200_0000, b: 32'h0100_0000, gap: 1'b1, exp: 32'h0300_0000, exp_sat: 1'b0};
    tbl[6] = '{a: 32'h0100_0000, b: 32'h0000_0000, gap: 1'b1, exp: 32'h0200_0000, exp_sat: 1'b0};
    tbl[7] = '{a: 32'h0000_0005, b: 32'h0000_0000, gap: 1'b1, exp: 32'h0000_0005, exp_sat: 1'b0};

    // Outputs must stay cleared while reset is held, whatever the inputs do.
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #2;
    expect_out("reset0", 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(i[0], 32'h0100_0000 + i);
      expect_out("reset_hold", 1'b0, 32'h0, 1'b0, 1'b0);
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    send(1'b0, '0);
    expect_out("post_reset", 1'b0, 32'h0, 1'b0, 1'b0);

    for (int f = 0; f < 8; f++) run_frame(tbl[f]);

    // Partial frame of 40 samples; previous tail is zero so outputs equal inputs.
    for (int k = 0; k < 40; k++) begin
      send(1'b1, 32'h1000 + k);
      if (k < 32) begin
        held = 32'h1000 + k;
        expect_out("partial_out", 1'b1, 32'h1000 + k, k == 31, 1'b0);
      end else begin
        expect_out("partial_tail", 1'b0, held, 1'b0, 1'b0);
      end
    end
    reset = 1'b0;
    #2;
    expect_out("async_reset", 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 32'hDEAD_0000 + i);
      expect_out("midreset_hold", 1'b0, 32'h0, 1'b0, 1'b0);
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    held     = '0;

    // Ramp after reset: tail cleared, so outputs are the ramp itself.
    for (int k = 0; k < 64; k++) begin
      send(1'b1, k);
      if (k < 32) begin
        held = k;
        expect_out("ramp1_out", 1'b1, k, k == 31, 1'b0);
      end else begin
        expect_out("ramp1_tail", 1'b0, held, 1'b0, 1'b0);
      end
    end
    // Second ramp adds sample k+32 of the first: k + (k+32).
    for (int k = 0; k < 32; k++) begin
      send(1'b1, k);
      held = 2 * k + 32;
      expect_out("ramp2_out", 1'b1, 2 * k + 32, k == 31, 1'b0);
    end
    send(1'b0, '0);
    expect_out("final_idle", 1'b0, held, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/overlap_add.md
OVERLAP_ADD -- requirements
Module: overlap_add

Interface
REQ-001 Parameter FRAME_LEN, default 64: samples per windowed frame; fixed to match the 64-entry analysis window.
REQ-002 Parameter HOP, default 32: samples output per frame; FRAME_LEN/2, giving 50% overlap.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data carries one synthesis-windowed frame sample this cycle.
REQ-006 in_data  input  32  signed, fixed-point (32,24); frame samples in order 0..63, frames back-to-back.
REQ-007 out_valid  output  1  out_data carries one reconstructed sample this cycle.
REQ-008 out_data  output  32  signed, fixed-point (32,24); reconstructed time-domain sample.
REQ-009 out_last  output  1  high with the final (32nd) output sample of each hop.
REQ-010 out_sat  output  1  high with an output sample whose sum was saturated.

Function
REQ-011 A 6-bit sample counter cnt shall advance by 1 on each in_valid cycle, wrap 63->0, and hold when in_valid is low.
REQ-012 A 32-entry x 32-bit tail buffer shall hold the second half of the previous frame.
REQ-013 When in_valid and cnt in 0..31, the block shall compute sum = in_data + tail[cnt] at 33 bits, sign-extended.
REQ-014 When in_valid and cnt in 32..63, the block shall write tail[cnt-32] = in_data and produce no output sample.
REQ-015 Saturation: sum > 0x7FFFFFFF -> 0x7FFFFFFF; sum < -0x80000000 -> 0x80000000; otherwise sum[31:0]; out_sat = 1 only when clamped.
REQ-016 Latency shall be exactly 1 cycle: out_valid, out_data, out_last and out_sat shall be registered from the input cycle.
REQ-017 out_valid shall be 1 exactly on the cycle after an in_valid cycle with cnt in 0..31, and 0 otherwise.
REQ-018 out_last shall be 1 only on the cycle after an in_valid cycle with cnt == 31.
REQ-019 When out_valid is 0, out_data shall hold its last value and out_last and out_sat shall be 0.
REQ-020 The tail read at cnt = k shall return the value written at cnt = k+32 of the immediately preceding frame.
REQ-021 No write to a tail entry shall occur in the same cycle as a read of that entry.
REQ-022 Idle cycles (in_valid low) anywhere in a frame shall not change results.
REQ-023 Output gain shall be unity, with no scaling; the periodic Hann at 50% overlap sums to approximately 1.0.

Reset
REQ-024 While reset is low: cnt = 0, all tail entries = 0, out_valid = 0, out_data = 0, out_last = 0, out_sat = 0, independent of clk.
REQ-025 Reset asserted mid-frame shall discard the partial frame; the next in_valid sample is frame sample 0.
REQ-026 After reset, the first frame shall overlap-add with zeros, so its outputs equal its inputs 0..31.

Verification
REQ-027 Reset: hold reset low, toggle inputs -> all outputs 0, no out_valid.
REQ-028 First frame after reset, 64 samples of 0x01000000 contiguous -> 32 outputs of 0x01000000, each 1 cycle after input; out_last on the 32nd; out_valid 0 during samples 32..63.
REQ-029 Second consecutive frame of 0x01000000 -> 32 outputs of 0x02000000, out_sat 0.
REQ-030 Saturation: frame A samples 32..63 = 0x7F000000, frame B samples 0..31 = 0x02000000 -> out_data 0x7FFFFFFF, out_sat 1; negative case 0x81000000 + 0xFE000000 -> 0x80000000, out_sat 1.
REQ-031 Gapped input: the same two frames with random in_valid gaps -> identical output sequence, with out_valid only 1 cycle after qualifying in_valid cycles.
REQ-032 Reset at cnt = 40 of a frame, then a frame of ramp values 0..63 -> outputs 0..31 exactly (tail cleared), out_last on value 31.
